register_file_1w_128b_multi_port_read_64b: RTL
==============================================

# register_file_1w_128b_multi_port_read_64b

Latch-based standard-cell memory with one 128-bit write port and N_READ independent 64-bit read ports. It is the wide-write / narrow-read counterpart of the team's 64b-write / 128b-read register file. A producer fills whole 128-bit lines, optionally with one 64-bit half masked off. Consumers such as narrow cores or DMA read beats fetch individual 64-bit halves. Storage is clock-gated latch rows; all control state is in flip-flops.

## Interface
- WADDR_WIDTH, 4: write address width, in 128-bit lines.
- RDATA_WIDTH, 64: read word width; one storage row.
- WDATA_WIDTH, 128: write word width; must equal 2*RDATA_WIDTH.
- RADDR_WIDTH, WADDR_WIDTH+1: read address width, in 64-bit rows.
- N_READ, 2: number of read ports.
- clk  in  1  clock; single domain.
- rst  in  1  reset; synchronous, active-high.
- ReadEnable  in  [N_READ]  per-port read request.
- ReadAddr  in  [N_READ][RADDR_WIDTH]  64-bit row address.
- ReadData  out  [N_READ][RDATA_WIDTH]  read data.
- ReadValid  out  [N_READ]  ReadData holds the result of an accepted request.
- WriteEnable  in  1  write request.
- WriteAddr  in  WADDR_WIDTH  128-bit line address.
- WriteBE  in  2  half enables: bit0 = low 64b (row 2a), bit1 = high 64b (row 2a+1).
- WriteData  in  WDATA_WIDTH  write data.

## Operation
- Storage: NUM_ROWS = 2**RADDR_WIDTH rows of RDATA_WIDTH bits, held in latches. Storage is not reset.
- Write sampling:
  - When WriteEnable=1 and WriteBE!=0 at an edge, WriteData is registered into WDataInt.
  - Row enable for row r = WriteEnable & (r>>1 == WriteAddr) & WriteBE[r[0]].
  - A global clock gate driven by WriteEnable feeds one cluster_clock_gating cell per row.
  - Row r latches WDataInt[r[0]*64 +: 64] while its gated clock is high.
- WriteEnable=1 with WriteBE=0 is a no-op: no gated clock pulses and WDataInt is held.
- Read, per port p, independent of the other ports:
  - When ReadEnable[p]=1 at an edge, ReadAddr[p] is registered into RAddrReg[p].
  - ReadData[p] = row[RAddrReg[p]].
  - ReadValid[p] <= ReadEnable[p] on every edge.
- ReadData is held stable until the next accepted read on that port, or until the addressed row is rewritten.
- Reset (rst=1 at an edge):
  - RAddrReg, WDataInt and ReadValid are cleared to 0.
  - Pending write gating is suppressed for that edge: the row enable is forced to 0 while rst=1.
  - A write sampled on the same edge as rst=1 is discarded.
- Several ports may read the same row in the same cycle; there is no arbitration and no port can stall.
- Address width rule: ReadAddr and WriteAddr cover the full space, so out-of-range addresses cannot occur and there is no wrap logic.

## Timing
- Write: a write sampled at edge E updates its row(s) during the high phase after E. The new data is readable by any read whose address is registered at edge E+1 or later.
- Read accepted at edge E:
  - Without the macro: ReadData and ReadValid are valid in cycle E..E+1 (latency 1).
  - With SCM_READ_OUT_REG_EN: valid one cycle later (latency 2).
- Read and write to the same row at the same edge E: the read returns the old data, or X in latch simulation. This case is documented as undefined; the bench must not check it. From E+1 the read returns the new data.
- Back-to-back writes are accepted every cycle. Back-to-back reads are accepted every cycle per port.
- Reset values of outputs:
  - ReadValid = 0 on all ports.
  - ReadData = row[0] content without the macro; 0 with the macro.

## Configuration
- SCM_READ_OUT_REG_EN defined:
  - Adds a flip-flop stage on ReadData and ReadValid per port, reset to 0.
  - Read latency becomes 2. Latch-to-output paths are cut.
  - ReadData output registers load only when the delayed enable is 1; otherwise they hold.
- SCM_READ_OUT_REG_EN undefined:
  - ReadData is combinational from latches via RAddrReg; latency 1.

## Structure
- Shared package scm_pkg holds:
  - SCM_WIDE_RATIO = 2.
  - typedef scm_half_be_t (logic [1:0]).
  - Constants SCM_BE_LO = 2'b01, SCM_BE_HI = 2'b10, SCM_BE_ALL = 2'b11.
- Sub-module: reuse the existing cluster_clock_gating, for one global gate plus NUM_ROWS row gates with test_en_i tied to 0. No new sub-module.
- Elaboration assertion: WDATA_WIDTH == 2*RDATA_WIDTH and RADDR_WIDTH == WADDR_WIDTH+1.

## Test plan
- Full write then read: write line 3 with 128'h1111..._2222..., BE=11. Port0 reads row 6 and gets 64'h2222...; port1 reads row 7 and gets 64'h1111.... ReadValid pulses at latency 1 (2 with the macro).
- Half write: line 3 preloaded as above; write line 3 with BE=10, data 128'hAAAA..._BBBB.... Row 6 remains 64'h2222...; row 7 becomes 64'hAAAA....
- BE=0 no-op: WriteEnable=1, BE=00, data all-F to line 0. Rows 0 and 1 keep their prior values, and WDataInt is unchanged.
- Concurrent ports: both ports read row 6 every cycle for 8 cycles while writes target line 5. Both ports return an identical stable 64'h2222... with ReadValid=1 throughout.
- Reset mid-operation: assert rst on the same edge as a write to line 2 and a read on port0. ReadValid=0, the line 2 contents are unchanged, and ReadData=0 with the macro.
- Write then immediate read: write line 1 at edge E and read row 2 registered at E+1. The read returns the new low half.

Source files
------------

// File: rtl/scm_pkg.sv
// Shared constants and types for the standard-cell-memory register files.
// Half-line byte-enable encoding for wide-write / narrow-read arrays.
package scm_pkg;

    localparam int SCM_WIDE_RATIO = 2;

    typedef logic [1:0] scm_half_be_t;

    localparam scm_half_be_t SCM_BE_LO  = 2'b01;
    localparam scm_half_be_t SCM_BE_HI  = 2'b10;
    localparam scm_half_be_t SCM_BE_ALL = 2'b11;

endpackage

// File: rtl/cluster_clock_gating.sv
// Latch-based integrated clock gate: enable captured while clk_i is low.
// Zero latency; no flow control.
module cluster_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_lat;

    always_latch begin
        if (!clk_i) begin
            en_lat <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_lat;

endmodule

// File: rtl/register_file_1w_128b_multi_port_read_64b.sv
// Latch SCM: one 128b write port (half enables), N_READ independent 64b read ports.
// Read latency 1, or 2 with SCM_READ_OUT_REG_EN; no backpressure, every port accepts every cycle.
module register_file_1w_128b_multi_port_read_64b
    import scm_pkg::*;
#(
    parameter int WADDR_WIDTH = 4,
    parameter int RDATA_WIDTH = 64,
    parameter int WDATA_WIDTH = 128,
    parameter int RADDR_WIDTH = WADDR_WIDTH + 1,
    parameter int N_READ      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_READ-1:0]                     ReadEnable,
    input  logic [N_READ-1:0][RADDR_WIDTH-1:0]    ReadAddr,
    output logic [N_READ-1:0][RDATA_WIDTH-1:0]    ReadData,
    output logic [N_READ-1:0]                     ReadValid,
    input  logic                                  WriteEnable,
    input  logic [WADDR_WIDTH-1:0]                WriteAddr,
    input  scm_half_be_t                          WriteBE,
    input  logic [WDATA_WIDTH-1:0]                WriteData
);

    localparam int NUM_ROWS = 2 ** RADDR_WIDTH;

    if (WDATA_WIDTH != SCM_WIDE_RATIO * RDATA_WIDTH || RADDR_WIDTH != WADDR_WIDTH + 1) begin : g_param_check
        $error("register_file_1w_128b_multi_port_read_64b: inconsistent width parameters");
    end

    logic                   write_fire;
    logic [WDATA_WIDTH-1:0] wdata_int_d, wdata_int_q;
    logic                   global_clk;
    logic [NUM_ROWS-1:0]    row_en;
    logic [NUM_ROWS-1:0]    row_clk;
    logic [RDATA_WIDTH-1:0] mem_rows [NUM_ROWS];

    logic [N_READ-1:0][RADDR_WIDTH-1:0] raddr_d, raddr_q;
    logic [N_READ-1:0]                  rvalid_d, rvalid_q;
    logic [N_READ-1:0][RDATA_WIDTH-1:0] rdata_raw;

    // An all-zero half mask or reset must not produce any gated clock pulse.
    assign write_fire = WriteEnable && (WriteBE != '0) && !rst;

    always_comb begin
        wdata_int_d = wdata_int_q;
        if (rst) begin
            wdata_int_d = '0;
        end else if (write_fire) begin
            wdata_int_d = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        wdata_int_q <= wdata_int_d;
    end

    cluster_clock_gating u_global_cg (
        .clk_i     (clk),
        .en_i      (write_fire),
        .test_en_i (1'b0),
        .clk_o     (global_clk)
    );

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        logic [RDATA_WIDTH-1:0] row_lat;

        assign row_en[r] = write_fire
                        && (WriteAddr == WADDR_WIDTH'(r / SCM_WIDE_RATIO))
                        && WriteBE[r % SCM_WIDE_RATIO];

        cluster_clock_gating u_row_cg (
            .clk_i     (global_clk),
            .en_i      (row_en[r]),
            .test_en_i (1'b0),
            .clk_o     (row_clk[r])
        );

        // Transparent during the high phase after the write edge, when wdata_int_q is already stable.
        always_latch begin
            if (row_clk[r]) begin
                row_lat <= wdata_int_q[(r % SCM_WIDE_RATIO)*RDATA_WIDTH +: RDATA_WIDTH];
            end
        end

        assign mem_rows[r] = row_lat;
    end

    always_comb begin
        raddr_d  = raddr_q;
        rvalid_d = ReadEnable;
        if (rst) begin
            raddr_d  = '0;
            rvalid_d = '0;
        end else begin
            for (int p = 0; p < N_READ; p++) begin
                if (ReadEnable[p]) begin
                    raddr_d[p] = ReadAddr[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        raddr_q  <= raddr_d;
        rvalid_q <= rvalid_d;
    end

    always_comb begin
        rdata_raw = '0;
        for (int p = 0; p < N_READ; p++) begin
            rdata_raw[p] = mem_rows[raddr_q[p]];
        end
    end

`ifdef SCM_READ_OUT_REG_EN
    logic [N_READ-1:0][RDATA_WIDTH-1:0] rdata_out_d, rdata_out_q;
    logic [N_READ-1:0]                  rvalid_out_d, rvalid_out_q;

    always_comb begin
        rdata_out_d  = rdata_out_q;
        rvalid_out_d = rvalid_q;
        if (rst) begin
            rdata_out_d  = '0;
            rvalid_out_d = '0;
        end else begin
            for (int p = 0; p < N_READ; p++) begin
                if (rvalid_q[p]) begin
                    rdata_out_d[p] = rdata_raw[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        rdata_out_q  <= rdata_out_d;
        rvalid_out_q <= rvalid_out_d;
    end

    assign ReadData  = rdata_out_q;
    assign ReadValid = rvalid_out_q;
`else
    assign ReadData  = rdata_raw;
    assign ReadValid = rvalid_q;
`endif

endmodule
